// File: rtl/memory_access_pkg.sv
// Shared decode constants and types for the MEM stage and its data memory.
package memory_access_pkg;

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SW  = 6'b101011;

  localparam logic [31:0] NOP_WORD = 32'd0;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } acc_size_e;

  typedef struct packed {
    logic      is_load;
    logic      is_store;
    acc_size_e size;
  } mem_dec_t;

  // Non-memory ops decode as a word access with both flags clear.
  function automatic mem_dec_t decode_op(input logic [5:0] op);
    mem_dec_t d;
    d = '{is_load: 1'b0, is_store: 1'b0, size: SZ_WORD};
    case (op)
      OP_LB, OP_LBU: begin d.is_load  = 1'b1; d.size = SZ_BYTE; end
      OP_LH, OP_LHU: begin d.is_load  = 1'b1; d.size = SZ_HALF; end
      OP_LW:         begin d.is_load  = 1'b1; d.size = SZ_WORD; end
      OP_SB:         begin d.is_store = 1'b1; d.size = SZ_BYTE; end
      OP_SH:         begin d.is_store = 1'b1; d.size = SZ_HALF; end
      OP_SW:         begin d.is_store = 1'b1; d.size = SZ_WORD; end
      default:       ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/memory_access_dm_byte_ram.sv
// Word-organised data memory: byte-lane synchronous write, combinational read,
// synchronous whole-array clear.
module dm_byte_ram #(
  parameter int unsigned WORDS = 4096
) (
  input  logic                       clk,
  input  logic                       clr,
  input  logic [3:0]                 we,
  input  logic [$clog2(WORDS)-1:0]   addr,
  input  logic [31:0]                wdata,
  output logic [31:0]                rdata
);

  logic [31:0] mem_q [WORDS];

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < int'(WORDS); i++) mem_q[i] <= '0;
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (we[b]) mem_q[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = mem_q[addr];

endmodule

// File: rtl/memory_access.sv
// MEM pipeline stage: load/store decode, byte-lane generation, load alignment
// and the MEM/WB register. MEM_ALIGN_CHECK_EN enables misalignment trapping.
module memory_access
  import memory_access_pkg::*;
#(
  parameter int unsigned DM_WORDS     = 4096,
  parameter int unsigned ALIGN_FLAG_W = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [31:0]             Inst_M,
  input  logic [31:0]             AO_M,
  input  logic [31:0]             RT_M,
  input  logic [31:0]             PC_M,
  output logic [31:0]             Inst_W,
  output logic [31:0]             AO_W,
  output logic [31:0]             MO_W,
  output logic [ALIGN_FLAG_W-1:0] align_err
);

  localparam int unsigned AW = $clog2(DM_WORDS);

  mem_dec_t          dec_c;
  logic [1:0]        off_c;
  logic [1:0]        eff_off_c;
  logic [AW-1:0]     idx_c;
  logic              misalign_raw_c;
  logic              suppress_c;
  logic [3:0]        be_c;
  logic [3:0]        we_c;
  logic [31:0]       wdata_c;
  logic [31:0]       rdata_c;
  logic [31:0]       load_data_c;
  logic              store_fire_c;

  logic [31:0]             inst_w_q, inst_w_d;
  logic [31:0]             ao_w_q, ao_w_d;
  logic [31:0]             mo_w_q, mo_w_d;
  logic [ALIGN_FLAG_W-1:0] align_err_q, align_err_d;

  assign dec_c = decode_op(Inst_M[31:26]);
  assign off_c = AO_M[1:0];
  assign idx_c = AO_M[AW+1:2];

  // Effective offset: halves/words drop the low address bits they cannot use.
  always_comb begin
    misalign_raw_c = 1'b0;
    eff_off_c      = off_c;
    case (dec_c.size)
      SZ_WORD: begin misalign_raw_c = (off_c != 2'b00); eff_off_c = 2'b00; end
      SZ_HALF: begin misalign_raw_c = off_c[0]; eff_off_c = {off_c[1], 1'b0}; end
      default: ;
    endcase
`ifdef MEM_ALIGN_CHECK_EN
    suppress_c = (dec_c.is_load | dec_c.is_store) & misalign_raw_c;
`else
    suppress_c = 1'b0;
`endif
  end

  always_comb begin
    be_c    = 4'b0000;
    wdata_c = '0;
    case (dec_c.size)
      SZ_WORD: begin be_c = 4'b1111; wdata_c = RT_M; end
      SZ_HALF: begin be_c = 4'(4'b0011 << eff_off_c); wdata_c = {2{RT_M[15:0]}}; end
      SZ_BYTE: begin be_c = 4'(4'b0001 << eff_off_c); wdata_c = {4{RT_M[7:0]}}; end
      default: ;
    endcase
    store_fire_c = dec_c.is_store & ~reset & ~suppress_c;
    we_c         = store_fire_c ? be_c : 4'b0000;
  end

  dm_byte_ram #(
    .WORDS (DM_WORDS)
  ) u_ram (
    .clk   (clk),
    .clr   (reset),
    .we    (we_c),
    .addr  (idx_c),
    .wdata (wdata_c),
    .rdata (rdata_c)
  );

  // Right-align the addressed lane; sign/zero extension is WB's job.
  always_comb begin
    load_data_c = '0;
    if (dec_c.is_load && !suppress_c) begin
      case (dec_c.size)
        SZ_WORD: load_data_c = rdata_c;
        SZ_HALF: load_data_c = eff_off_c[1] ? {16'h0000, rdata_c[31:16]} : rdata_c;
        SZ_BYTE: load_data_c = rdata_c >> {eff_off_c, 3'b000};
        default: load_data_c = '0;
      endcase
    end
  end

  always_comb begin
    inst_w_d    = reset ? NOP_WORD : Inst_M;
    ao_w_d      = reset ? 32'd0 : AO_M;
    mo_w_d      = reset ? 32'd0 : load_data_c;
`ifdef MEM_ALIGN_CHECK_EN
    align_err_d = reset ? '0 : (align_err_q | {ALIGN_FLAG_W{suppress_c}});
`else
    align_err_d = '0;
`endif
  end

  always_ff @(posedge clk) begin
    inst_w_q    <= inst_w_d;
    ao_w_q      <= ao_w_d;
    mo_w_q      <= mo_w_d;
    align_err_q <= align_err_d;
  end

  assign Inst_W    = inst_w_q;
  assign AO_W      = ao_w_q;
  assign MO_W      = mo_w_q;
  assign align_err = align_err_q;

  // PC_M only feeds the simulation store trace.
  logic unused_c;
  assign unused_c = ^{PC_M, misalign_raw_c};

endmodule

// File: tb/tb_memory_access.sv
// Scoreboard bench for memory_access: directed MEM-stage vectors, monitor
// compares the MEM/WB register each cycle, plus a store trace.
module tb_memory_access;
  import memory_access_pkg::*;

`ifdef MEM_ALIGN_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] Inst_M = '0, AO_M = '0, RT_M = '0, PC_M = '0;
  logic [31:0] Inst_W, AO_W, MO_W;
  logic [0:0]  align_err;

  memory_access #(.DM_WORDS(4096), .ALIGN_FLAG_W(1)) dut (
    .clk(clk), .reset(reset), .Inst_M(Inst_M), .AO_M(AO_M), .RT_M(RT_M),
    .PC_M(PC_M), .Inst_W(Inst_W), .AO_W(AO_W), .MO_W(MO_W), .align_err(align_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] inst;
    logic [31:0] ao;
    logic [31:0] mo;
    logic        al;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  int          traces = 0;
  logic [31:0] pc_ctr = 32'h0000_3000;

  function automatic logic [31:0] mk(input logic [5:0] op);
    return {op, 26'h0410000};
  endfunction

  task automatic check(input string name, input string field,
                       input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s got %h want %h", name, field, act, exp);
    end
  endtask

  task automatic issue(input string name, input bit rst, input logic [31:0] inst,
                       input logic [31:0] ao, input logic [31:0] rt,
                       input logic [31:0] mo, input bit al);
    exp_t e;
    @(negedge clk);
    reset  = rst;
    Inst_M = inst;
    AO_M   = ao;
    RT_M   = rt;
    PC_M   = pc_ctr;
    pc_ctr = pc_ctr + 32'd4;
    e.name = name;
    e.inst = rst ? NOP_WORD : inst;
    e.ao   = rst ? 32'd0 : ao;
    e.mo   = rst ? 32'd0 : mo;
    e.al   = rst ? 1'b0 : al;
    sb_q.push_back(e);
  endtask

  // Monitor: the MEM/WB register is presented every cycle after the edge.
  always @(posedge clk) begin
    #1;
    if (sb_q.size() != 0) begin
      mon_e = sb_q.pop_front();
      check(mon_e.name, "Inst_W", Inst_W, mon_e.inst);
      check(mon_e.name, "AO_W", AO_W, mon_e.ao);
      check(mon_e.name, "MO_W", MO_W, mon_e.mo);
      check(mon_e.name, "align_err", {31'd0, align_err}, {31'd0, mon_e.al});
    end
  end

  // Store trace: time, PC, word-aligned address, resulting word.
  always @(posedge clk) begin
    logic [31:0] t_pc, t_addr;
    logic [11:0] t_idx;
    if (dut.store_fire_c) begin
      t_pc   = PC_M;
      t_addr = {AO_M[31:2], 2'b00};
      t_idx  = AO_M[13:2];
      #1;
      traces++;
      $display("TRACE t=%0t pc=%h addr=%h word=%h", $time, t_pc, t_addr,
               dut.u_ram.mem_q[t_idx]);
    end
  end

  initial begin
    int wait_cyc;
    issue("rst",    1, NOP_WORD,   32'h0, 32'h0, 32'h0, 1'b0);
    issue("sw10",   0, mk(OP_SW),  32'h10, 32'h12345678, 32'h0, 1'b0);
    issue("lw10",   0, mk(OP_LW),  32'h10, 32'h0, 32'h12345678, 1'b0);
    issue("sb12",   0, mk(OP_SB),  32'h12, 32'h111111AB, 32'h0, 1'b0);
    issue("lw10b",  0, mk(OP_LW),  32'h10, 32'h0, 32'h12AB5678, 1'b0);
    issue("lbu13",  0, mk(OP_LBU), 32'h13, 32'h0, 32'h00000012, 1'b0);
    issue("lb11",   0, mk(OP_LB),  32'h11, 32'h0, 32'h0012AB56, 1'b0);
    issue("sh22",   0, mk(OP_SH),  32'h22, 32'h1234BEEF, 32'h0, 1'b0);
    issue("lh22",   0, mk(OP_LH),  32'h22, 32'h0, 32'h0000BEEF, 1'b0);
    issue("lhu22",  0, mk(OP_LHU), 32'h22, 32'h0, 32'h0000BEEF, 1'b0);
    issue("lw20",   0, mk(OP_LW),  32'h20, 32'h0, 32'hBEEF0000, 1'b0);
    issue("addu",   0, 32'h00851821, 32'h55, 32'hFFFFFFFF, 32'h0, 1'b0);
    issue("lw10c",  0, mk(OP_LW),  32'h10, 32'h0, 32'h12AB5678, 1'b0);
    issue("lwhi",   0, mk(OP_LW),  32'h4010, 32'h0, 32'h12AB5678, 1'b0);
    issue("sw11",   0, mk(OP_SW),  32'h11, 32'hDEADBEEF, 32'h0, CHK);
    issue("lw10d",  0, mk(OP_LW),  32'h10, 32'h0, CHK ? 32'h12AB5678 : 32'hDEADBEEF, CHK);
    issue("lw12",   0, mk(OP_LW),  32'h12, 32'h0, CHK ? 32'h0 : 32'hDEADBEEF, CHK);
    issue("lh23",   0, mk(OP_LH),  32'h23, 32'h0, CHK ? 32'h0 : 32'h0000BEEF, CHK);
    issue("swrst",  1, mk(OP_SW),  32'h30, 32'h0BADF00D, 32'h0, 1'b0);
    issue("lw30",   0, mk(OP_LW),  32'h30, 32'h0, 32'h0, 1'b0);
    issue("lw10e",  0, mk(OP_LW),  32'h10, 32'h0, 32'h0, 1'b0);
    issue("sb31",   0, mk(OP_SB),  32'h31, 32'h00000077, 32'h0, 1'b0);
    issue("lw30b",  0, mk(OP_LW),  32'h30, 32'h0, 32'h00007700, 1'b0);
    issue("sw40",   0, mk(OP_SW),  32'h40, 32'hCAFEBABE, 32'h0, 1'b0);
    issue("lwrst",  1, mk(OP_LW),  32'h40, 32'h0, 32'h0, 1'b0);
    issue("lw40",   0, mk(OP_LW),  32'h40, 32'h0, 32'h0, 1'b0);
    issue("nop",    0, NOP_WORD,   32'h0, 32'h0, 32'h0, 1'b0);

    @(negedge clk);
    Inst_M = NOP_WORD;
    AO_M   = '0;
    RT_M   = '0;
    wait_cyc = 0;
    while (sb_q.size() != 0 && wait_cyc < 20) begin
      @(negedge clk);
      wait_cyc++;
    end
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d want 0", sb_q.size());
    end
    repeat (2) @(negedge clk);
    check("trace", "count", 32'(traces), CHK ? 32'd5 : 32'd6);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
